c5_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares the c5_soc external pipelined Wishbone memory port among NUM_M internal masters (CPU fetch, CPU data, video DMA, ...).
- The port signals are O_cyc/O_stb/O_we/O_adr/O_dat/I_stall/I_ack/I_dat.
- Grants the port to one master per bus cycle (cyc-held ownership) and muxes the slave response back to it.
- Aborts hung cycles with a watchdog error.

---
 rtl/c5_bus_arbiter.sv | 105 ++++++++++
 tb/tb_c5_bus_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/c5_bus_arbiter.sv
// c5_bus_arbiter: round-robin owner of the external pipelined Wishbone port
//   I_clk, I_rst                 clock, synchronous active-low reset
//   I_m_cyc/stb/we/adr/dat       per-master requests (adr/dat packed by index)
//   O_m_stall/ack/err, O_m_dat   per-master responses, read data broadcast
//   O_gnt                        one-hot owner, 0 when none
//   O_cyc/stb/we/adr/dat         muxed request to slave
//   I_stall/ack/dat              slave response
module c5_bus_arbiter #(
  parameter int NUM_M = 3,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic [NUM_M-1:0]    I_m_cyc,
  input  logic [NUM_M-1:0]    I_m_stb,
  input  logic [NUM_M-1:0]    I_m_we,
  input  logic [NUM_M*AW-1:0] I_m_adr,
  input  logic [NUM_M*DW-1:0] I_m_dat,
  output logic [NUM_M-1:0]    O_m_stall,
  output logic [NUM_M-1:0]    O_m_ack,
  output logic [NUM_M-1:0]    O_m_err,
  output logic [DW-1:0]       O_m_dat,
  output logic [NUM_M-1:0]    O_gnt,
  output logic                O_cyc,
  output logic                O_stb,
  output logic                O_we,
  output logic [AW-1:0]       O_adr,
  output logic [DW-1:0]       O_dat,
  input  logic                I_stall,
  input  logic                I_ack,
  input  logic [DW-1:0]       I_dat
);
  localparam int IW = $clog2(NUM_M);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;
  state_t state, state_nx;
  logic [IW-1:0] owner, owner_nx, ptr, ptr_nx, win, j;
  logic [CW-1:0] cnt, cnt_nx;
  logic [NUM_M-1:0] onehot;
  logic found, own, arb, timeout;
  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      state <= IDLE;
      owner <= '0;
      ptr <= IW'(NUM_M - 1);
      cnt <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      ptr <= ptr_nx;
      cnt <= cnt_nx;
    end
  end
  // descending scan so the nearest requester after ptr is written last
  always_comb begin
    win = '0;
    j = '0;
    found = 1'b0;
    for (int k = NUM_M; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % NUM_M);
      if (I_m_cyc[j]) begin
        win = j;
        found = 1'b1;
      end
    end
  end
  // the Nth consecutive unacked cycle (counter at TIMEOUT-1) triggers the abort
  always_comb begin
    own = state == OWN;
    arb = state == IDLE || (own && !I_m_cyc[owner]);
    timeout = own && I_m_cyc[owner] && !I_ack && cnt == CW'(TIMEOUT - 1);
    state_nx = state;
    owner_nx = owner;
    ptr_nx = ptr;
    cnt_nx = cnt;
    if (state == ABORT) begin
      state_nx = IDLE;
    end else if (arb) begin
      state_nx = found ? OWN : IDLE;
      owner_nx = found ? win : owner;
      ptr_nx = found ? win : ptr;
      cnt_nx = found ? '0 : cnt;
    end else if (timeout) begin
      state_nx = ABORT;
      cnt_nx = '0;
    end else if (own) begin
      cnt_nx = I_ack ? '0 : cnt + 1'b1;
    end
  end
  always_comb begin
    onehot = NUM_M'(1) << owner;
    O_gnt = own ? onehot : '0;
    O_cyc = own & I_m_cyc[owner];
    O_stb = own & I_m_stb[owner];
    O_we = own & I_m_we[owner];
    O_adr = own ? I_m_adr[owner*AW +: AW] : '0;
    O_dat = own ? I_m_dat[owner*DW +: DW] : '0;
    O_m_stall = own ? (~onehot | ({NUM_M{I_stall}} & onehot)) : '1;
    O_m_ack = {NUM_M{own & I_ack}} & onehot;
    O_m_err = {NUM_M{state == ABORT}} & onehot;
    O_m_dat = I_dat;
  end
endmodule

// File: tb/tb_c5_bus_arbiter.sv
// tb_c5_bus_arbiter: directed scoreboard bench for c5_bus_arbiter (TIMEOUT=4)
module tb_c5_bus_arbiter;
  logic clk = 1'b0, rst;
  logic [2:0] m_cyc, m_stb, m_we, m_stall, m_ack, m_err, gnt;
  logic [95:0] m_adr, m_dat;
  logic [31:0] m_rdat, adr, wdat, dat;
  logic o_cyc, o_stb, o_we, stall, ack;
  int nv = 0, nerr = 0, acks;
  logic [2:0] q[$];
  logic [9:0] stb_v = 10'b0000111111, stall_v = 10'b0000000110, ack_v = 10'b0001110010;
  always #5 clk = ~clk;
  c5_bus_arbiter #(.NUM_M(3), .AW(32), .DW(32), .TIMEOUT(4)) dut (
    .I_clk(clk), .I_rst(rst), .I_m_cyc(m_cyc), .I_m_stb(m_stb), .I_m_we(m_we),
    .I_m_adr(m_adr), .I_m_dat(m_dat), .O_m_stall(m_stall), .O_m_ack(m_ack),
    .O_m_err(m_err), .O_m_dat(m_rdat), .O_gnt(gnt), .O_cyc(o_cyc), .O_stb(o_stb),
    .O_we(o_we), .O_adr(adr), .O_dat(wdat), .I_stall(stall), .I_ack(ack), .I_dat(dat)
  );
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nv++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic sb_pop(input string tag);
    if (q.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
    else chk(tag, 64'(m_ack), 64'(q.pop_front()));
  endtask
  task automatic ack_beat(input logic [31:0] d);
    ack = 1'b1;
    dat = d;
    #1;
    sb_pop("ack_route");
    chk("rdat", m_rdat, d);
  endtask
  task automatic do_reset;
    rst = 1'b0;
    m_cyc = '0;
    m_stb = '0;
    stall = 1'b0;
    ack = 1'b0;
    nxt;
    rst = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time bound expired");
  end
  initial begin
    rst = 1'b0; m_cyc = '1; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
    stall = 1'b0; ack = 1'b0; dat = '0;
    repeat (3) begin
      nxt;
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_cyc", o_cyc, 0);
      chk("rst_stall", m_stall, 3'b111);
      chk("rst_ackerr", {m_ack, m_err}, 0);
      chk("rst_adr", adr, 0);
    end
    rst = 1'b1;
    nxt;
    #1;
    chk("rel_gnt", gnt, 3'b001);
    chk("rel_cyc", o_cyc, 1);
    m_cyc = '0;
    do_reset;
    m_cyc = 3'b101; m_stb = 3'b101;
    m_adr[0 +: 32] = 32'h100; m_adr[64 +: 32] = 32'h200; m_dat[0 +: 32] = 32'hD0;
    nxt;
    #1;
    chk("rr_gnt0", gnt, 3'b001);
    chk("rr_adr0", adr, 32'h100);
    chk("rr_stb0", o_stb, 1);
    chk("rr_wdat0", wdat, 32'hD0);
    chk("rr_stall2", m_stall, 3'b110);
    q.push_back(3'b001);
    nxt;
    m_stb[0] = 1'b0;
    ack_beat(32'hA0);
    nxt;
    ack = 1'b0; m_cyc[0] = 1'b0;
    #1;
    chk("rr_hold_gnt", gnt, 3'b001);
    chk("rr_hold_cyc", o_cyc, 0);
    nxt;
    #1;
    chk("rr_gnt2", gnt, 3'b100);
    chk("rr_adr2", adr, 32'h200);
    q.push_back(3'b100);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0 +: 32] = 32'h104;
    nxt;
    m_stb[2] = 1'b0;
    ack_beat(32'hA2);
    nxt;
    ack = 1'b0; m_cyc[2] = 1'b0;
    nxt;
    #1;
    chk("rr_gnt0_again", gnt, 3'b001);
    chk("rr_adr0_again", adr, 32'h104);
    q.push_back(3'b001);
    nxt;
    m_stb[0] = 1'b0;
    ack_beat(32'hA4);
    nxt;
    ack = 1'b0; m_cyc[0] = 1'b0;
    do_reset;
    m_cyc = 3'b010; m_adr[32 +: 32] = 32'h300;
    nxt;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      m_stb[1] = stb_v[k]; stall = stall_v[k]; ack = ack_v[k];
      #1;
      chk("hold_gnt", gnt, 3'b010);
      chk("hold_stall1", m_stall[1], stall_v[k]);
      chk("hold_stall0", m_stall[0], 1);
      chk("hold_err", m_err, 0);
      if (stb_v[k] && !stall_v[k]) q.push_back(3'b010);
      if (ack_v[k]) sb_pop("hold_ack");
      else chk("hold_noack", m_ack, 0);
      acks += int'(m_ack[1]);
      nxt;
    end
    chk("hold_ack_count", acks, 4);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; stall = 1'b0; ack = 1'b0;
    nxt;
    #1;
    chk("hold_handover", gnt, 3'b001);
    m_cyc = '0;
    do_reset;
    m_cyc = 3'b001; m_stb = 3'b001; m_adr[0 +: 32] = 32'h400;
    nxt;
    for (int u = 0; u < 4; u++) begin
      #1;
      chk("wd_gnt", gnt, 3'b001);
      chk("wd_noerr", m_err, 0);
      m_stb = '0;
      nxt;
    end
    #1;
    chk("wd_err", m_err, 3'b001);
    chk("wd_abort_cyc", o_cyc, 0);
    chk("wd_abort_stall", m_stall, 3'b111);
    chk("wd_abort_gnt", gnt, 0);
    m_cyc = '0;
    nxt;
    #1;
    chk("wd_err_once", m_err, 0);
    chk("wd_idle_gnt", gnt, 0);
    do_reset;
    m_cyc = 3'b001; m_stb = 3'b001;
    nxt;
    q.push_back(3'b001);
    for (int u = 0; u < 4; u++) begin
      ack = (u == 3);
      dat = 32'h55;
      #1;
      chk("late_gnt", gnt, 3'b001);
      chk("late_noerr", m_err, 0);
      if (u == 3) sb_pop("late_ack");
      m_stb = '0;
      nxt;
    end
    ack = 1'b0;
    for (int u = 0; u < 4; u++) begin
      #1;
      chk("clr_gnt", gnt, 3'b001);
      chk("clr_noerr", m_err, 0);
      nxt;
    end
    #1;
    chk("clr_err", m_err, 3'b001);
    m_cyc = '0;
    nxt;
    do_reset;
    m_cyc = 3'b100; m_stb = 3'b100; m_adr[64 +: 32] = 32'h600;
    nxt;
    #1;
    chk("mid_gnt", gnt, 3'b100);
    nxt;
    ack = 1'b1;
    #1;
    chk("mid_ack", m_ack, 3'b100);
    nxt;
    rst = 1'b0;
    nxt;
    rst = 1'b1; m_cyc = 3'b101; m_stb = 3'b101;
    #1;
    chk("mid_rst_cyc", o_cyc, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_ackerr", {m_ack, m_err}, 0);
    chk("mid_rst_stall", m_stall, 3'b111);
    nxt;
    ack = 1'b0;
    #1;
    chk("mid_rr_ptr", gnt, 3'b001);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule
